// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost exit-code monitor.
package tohost_pkg;

  localparam logic [31:0] TOHOST_PASS_VALUE  = 32'd1;
  localparam logic [31:0] TOHOST_CLEAR_VALUE = 32'd0;
  localparam int unsigned FAIL_CODE_WIDTH    = 31;
  localparam int unsigned TOHOST_ODD_BIT     = 0;
  localparam int unsigned BLINK_PORT_WIDTH   = 4;

  // LED sequencer states; PASS is steady on, FAIL_* form the blink code.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_FAIL_ON,
    ST_FAIL_OFF,
    ST_FAIL_GAP
  } tohost_state_e;

  typedef enum logic [1:0] {
    CLS_IGNORE,
    CLS_PASS,
    CLS_FAIL
  } tohost_class_e;

  // Decode a full-word tohost value: 0 is a clear, even is a host call, 1 passes, other odd fails.
  function automatic tohost_class_e classify(input logic [31:0] data);
    if (data == TOHOST_CLEAR_VALUE) return CLS_IGNORE;
    if (data == TOHOST_PASS_VALUE) return CLS_PASS;
    if (data[TOHOST_ODD_BIT]) return CLS_FAIL;
    return CLS_IGNORE;
  endfunction

  // Saturate a fail code to the blink limit.
  function automatic logic [BLINK_PORT_WIDTH-1:0] blink_target(
    input logic [FAIL_CODE_WIDTH-1:0] code,
    input logic [FAIL_CODE_WIDTH-1:0] cap
  );
    return (code > cap) ? BLINK_PORT_WIDTH'(cap) : BLINK_PORT_WIDTH'(code);
  endfunction

endpackage

// File: rtl/led_blinker.sv
// LED sequencer: steady on for pass (count==0), repeating N-blink code for fail.
module led_blinker
  import tohost_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 100000000,
  parameter int unsigned MAX_BLINKS   = 15
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BLINK_PORT_WIDTH-1:0] count,
  output logic                        led
);

  localparam int unsigned MAX_PHASE = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
  localparam int unsigned PW        = $clog2(MAX_PHASE) + 1;
  localparam int unsigned BW_RAW    = $clog2(MAX_BLINKS + 1);
  localparam int unsigned BW        = (BW_RAW > 4) ? BW_RAW : 4;
  localparam logic [PW-1:0] BLINK_LAST = PW'(BLINK_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

  tohost_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [BW-1:0] target_q, target_d;
  logic          led_q, led_d;

  // Next-state, phase and blink-count sequencing.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + PW'(1);
    blink_d  = blink_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start) begin
          target_d = BW'(count);
          state_d  = (count == '0) ? ST_PASS : ST_FAIL_ON;
        end
      end
      ST_PASS: phase_d = '0;
      ST_FAIL_ON: begin
        if (phase_q == BLINK_LAST) begin
          phase_d = '0;
          state_d = ST_FAIL_OFF;
        end
      end
      ST_FAIL_OFF: begin
        if (phase_q == BLINK_LAST) begin
          phase_d = '0;
          if ((blink_q + BW'(1)) < target_q) begin
            blink_d = blink_q + BW'(1);
            state_d = ST_FAIL_ON;
          end else begin
            state_d = ST_FAIL_GAP;
          end
        end
      end
      ST_FAIL_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          blink_d = '0;
          state_d = ST_FAIL_ON;
        end
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    led_d = (state_d == ST_PASS) || (state_d == ST_FAIL_ON);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      blink_q  <= '0;
      target_q <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      target_q <= target_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/tohost_monitor.sv
// Snoops data-memory stores to tohost and latches the riscv-tests verdict.
// Optional macro TOHOST_CYCLE_COUNT_EN adds the reset-to-verdict cycle counter.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned TOHOST_ADDR  = 16384,
  parameter int unsigned BLINK_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 100000000,
  parameter int unsigned MAX_BLINKS   = 15
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       mem_wr_en,
  input  logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  input  logic [3:0]                 mem_wr_be,
  input  logic [31:0]                mem_wr_data,
  output logic                       done,
  output logic                       pass,
  output logic [FAIL_CODE_WIDTH-1:0] fail_code,
  output logic                       led,
  output logic [31:0]                done_cycles
);

  localparam logic [ADDR_WIDTH-1:0]      TOHOST_A  = ADDR_WIDTH'(TOHOST_ADDR);
  localparam int unsigned                CAP_INT   = (MAX_BLINKS > 15) ? 15 : MAX_BLINKS;
  localparam logic [FAIL_CODE_WIDTH-1:0] BLINK_CAP = FAIL_CODE_WIDTH'(CAP_INT);

  logic                       hit, capture;
  tohost_class_e              cls;
  logic                       done_q, done_d;
  logic                       pass_q, pass_d;
  logic [FAIL_CODE_WIDTH-1:0] code_q, code_d;
  logic [BLINK_PORT_WIDTH-1:0] blink_count;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^mem_wr_addr[1:0];

  // Full-word store to the tohost word, byte offset ignored.
  always_comb begin
    hit = mem_wr_en && (mem_wr_be == 4'b1111) &&
          (mem_wr_addr[ADDR_WIDTH-1:2] == TOHOST_A[ADDR_WIDTH-1:2]);
    cls = classify(mem_wr_data);
    capture = hit && !done_q && (cls != CLS_IGNORE);
  end

  // Verdict next-state; sticky once done.
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    code_d = code_q;
    blink_count = '0;
    if (capture) begin
      done_d = 1'b1;
      if (cls == CLS_PASS) begin
        pass_d = 1'b1;
        code_d = '0;
      end else begin
        pass_d = 1'b0;
        code_d = mem_wr_data[31:1];
        blink_count = blink_target(mem_wr_data[31:1], BLINK_CAP);
      end
    end
  end

  // Verdict registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      code_q <= '0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
      code_q <= code_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;

  led_blinker #(
    .BLINK_CYCLES (BLINK_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .MAX_BLINKS   (MAX_BLINKS)
  ) u_blinker (
    .sysclk (sysclk),
    .rst    (rst),
    .start  (capture),
    .count  (blink_count),
    .led    (led)
  );

`ifdef TOHOST_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] done_cycles_q, done_cycles_d;

  // Saturating run counter, frozen into done_cycles at capture.
  always_comb begin
    cyc_d         = cyc_q;
    done_cycles_d = done_cycles_q;
    if (!done_q && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;
    if (capture) done_cycles_d = cyc_q;
  end

  // Cycle counter registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cyc_q         <= '0;
      done_cycles_q <= '0;
    end else begin
      cyc_q         <= cyc_d;
      done_cycles_q <= done_cycles_d;
    end
  end

  assign done_cycles = done_cycles_q;
`else
  assign done_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: vector table plus blink/sticky/reset/count sequences.
module tb_tohost_monitor;

  localparam int unsigned BLINK = 4;
  localparam int unsigned GAP   = 16;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [3:0]  mem_wr_be;
  logic [31:0] mem_wr_data;
  logic        done, pass, led;
  logic [30:0] fail_code;
  logic [31:0] done_cycles;

  int checks = 0;
  int errors = 0;

  tohost_monitor #(
    .ADDR_WIDTH   (16),
    .TOHOST_ADDR  (16384),
    .BLINK_CYCLES (BLINK),
    .GAP_CYCLES   (GAP),
    .MAX_BLINKS   (15)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_be   (mem_wr_be),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .led         (led),
    .done_cycles (done_cycles)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        done;
    logic        pass;
    logic [30:0] code;
    logic        led;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    mem_wr_en   = 1'b1;
    mem_wr_addr = a;
    mem_wr_be   = be;
    mem_wr_data = d;
    tick();
    mem_wr_en   = 1'b0;
  endtask

  // Check LED blink code of n blinks for the given number of periods, starting at t=0.
  task automatic check_blink(input int n, input int periods, input string tag);
    int period;
    logic exp;
    period = n * 2 * BLINK + GAP;
    for (int t = 0; t < periods * period; t++) begin
      int tt;
      tt = t % period;
      exp = (tt < n * 2 * BLINK) && ((tt % (2 * BLINK)) < BLINK);
      check($sformatf("%s_led_t%0d", tag, t), {31'd0, led}, {31'd0, exp});
      tick();
    end
  endtask

  task automatic check_verdict(input string tag, input logic d, input logic p, input logic [30:0] c);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    check({tag, "_code"}, {1'b0, fail_code}, {1'b0, c});
  endtask

  initial begin
    logic [31:0] exp_cycles;

    vecs[0]  = '{1'b1, 16'h4000, 4'hF, 32'd1,          1'b1, 1'b1, 31'd0,          1'b1};
    vecs[1]  = '{1'b1, 16'h4000, 4'hF, 32'd7,          1'b1, 1'b0, 31'd3,          1'b1};
    vecs[2]  = '{1'b1, 16'h4000, 4'hF, 32'd0,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[3]  = '{1'b1, 16'h4000, 4'hF, 32'd8,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[4]  = '{1'b1, 16'h4000, 4'h1, 32'd1,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[5]  = '{1'b1, 16'h4004, 4'hF, 32'd1,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[6]  = '{1'b1, 16'h4003, 4'hF, 32'd1,          1'b1, 1'b1, 31'd0,          1'b1};
    vecs[7]  = '{1'b1, 16'h4000, 4'hF, 32'd201,        1'b1, 1'b0, 31'd100,        1'b1};
    vecs[8]  = '{1'b0, 16'h4000, 4'hF, 32'd1,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[9]  = '{1'b1, 16'h4000, 4'hF, 32'hFFFF_FFFF,  1'b1, 1'b0, 31'h7FFF_FFFF,  1'b1};
    vecs[10] = '{1'b1, 16'h4000, 4'hF, 32'd2,          1'b0, 1'b0, 31'd0,          1'b0};
    vecs[11] = '{1'b1, 16'h0000, 4'hF, 32'd1,          1'b0, 1'b0, 31'd0,          1'b0};

    rst = 1'b1;
    mem_wr_en = 1'b0;
    mem_wr_addr = '0;
    mem_wr_be = '0;
    mem_wr_data = '0;

`ifdef TOHOST_CYCLE_COUNT_EN
    exp_cycles = 32'd50;
`else
    exp_cycles = 32'd0;
`endif

    // Reset state.
    do_reset();
    check_verdict("reset", 1'b0, 1'b0, 31'd0);
    check("reset_led", {31'd0, led}, 32'd0);
    check("reset_cycles", done_cycles, 32'd0);

    // Single-store vectors, each from a fresh reset.
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      mem_wr_en   = vecs[i].en;
      mem_wr_addr = vecs[i].addr;
      mem_wr_be   = vecs[i].be;
      mem_wr_data = vecs[i].data;
      tick();
      mem_wr_en = 1'b0;
      check_verdict($sformatf("vec%0d", i), vecs[i].done, vecs[i].pass, vecs[i].code);
      check($sformatf("vec%0d_led", i), {31'd0, led}, {31'd0, vecs[i].led});
    end

    // Pass: LED held steady.
    do_reset();
    store(16'h4000, 4'hF, 32'd1);
    check_verdict("pass", 1'b1, 1'b1, 31'd0);
    for (int t = 0; t < 200; t++) begin
      check($sformatf("pass_led_t%0d", t), {31'd0, led}, 32'd1);
      tick();
    end

    // Fail code 3: two full blink periods.
    do_reset();
    store(16'h4000, 4'hF, 32'd7);
    check_verdict("fail3", 1'b1, 1'b0, 31'd3);
    check_blink(3, 2, "fail3");

    // Ignored writes in sequence, then a real pass.
    do_reset();
    store(16'h4000, 4'hF, 32'd0);
    check("ign_zero_done", {31'd0, done}, 32'd0);
    store(16'h4000, 4'hF, 32'd8);
    check("ign_even_done", {31'd0, done}, 32'd0);
    store(16'h4000, 4'h1, 32'd1);
    check("ign_partial_done", {31'd0, done}, 32'd0);
    store(16'h4004, 4'hF, 32'd1);
    check("ign_addr_done", {31'd0, done}, 32'd0);
    store(16'h4000, 4'hF, 32'd1);
    check_verdict("ign_then_pass", 1'b1, 1'b1, 31'd0);

    // Sticky verdict and blink saturation at 15.
    do_reset();
    store(16'h4000, 4'hF, 32'd201);
    check_verdict("sat", 1'b1, 1'b0, 31'd100);
    check_blink(15, 1, "sat");
    check_blink(15, 1, "sat2");
    store(16'h4000, 4'hF, 32'd1);
    check_verdict("sticky", 1'b1, 1'b0, 31'd100);

    // Reset in the middle of an on phase.
    do_reset();
    store(16'h4000, 4'hF, 32'd7);
    tick();
    check("midrst_led_before", {31'd0, led}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_verdict("midrst", 1'b0, 1'b0, 31'd0);
    check("midrst_led", {31'd0, led}, 32'd0);
    tick();
    check("midrst_led_idle", {31'd0, led}, 32'd0);
    store(16'h4000, 4'hF, 32'd1);
    check_verdict("midrst_pass", 1'b1, 1'b1, 31'd0);
    check("midrst_pass_led", {31'd0, led}, 32'd1);

    // Reset-to-verdict cycle count.
    do_reset();
    repeat (50) tick();
    check("cyc_before_done", done_cycles, 32'd0);
    store(16'h4000, 4'hF, 32'd1);
    check("cyc_value", done_cycles, exp_cycles);
    repeat (10) tick();
    check("cyc_hold", done_cycles, exp_cycles);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
